nvram_backup_ctl: RTL and testbench
===================================

// Module: nvram_backup_ctl
// PURPOSE
//  Sequences battery-backup RAM save/load between the user_io SD sector interface and port B of the
//  cartridge nvram dual-port RAM. Arms only after a ROM download with a mounted save image, streams
//  2^SECTORS_LOG2 x 512-byte sectors per slot, and drives buffer port B address/write-enable.
//  Sits between user_io (sd_* signals) and the nvram dpram beside the system core.
// PARAMETERS
//  SECTORS_LOG2  6         log2 sectors per slot (6 -> 64 sectors = 32 KB nvram)
//  SLOT_BITS     2         slot select width; slot occupies sd_lba[SECTORS_LOG2+SLOT_BITS-1:SECTORS_LOG2]
//  TIMEOUT       24'hFFFFFF clk_sys cycles allowed from request to sd_ack rise before abort
//  AUTOSAVE_DLY  24'h800000 idle cycles after last nvram write before autosave (BK_AUTOSAVE_EN only)
// PORTS
//  clk_sys       in  1   system clock
//  reset         in  1   synchronous, active-high
//  downloading   in  1   ioctl_download from data_io
//  img_mounted   in  1   save image mounted strobe (user_io)
//  img_size      in  32  mounted image size, bytes
//  bk_load       in  1   OSD load request (level; rising edge acts)
//  bk_save       in  1   OSD save request (level; rising edge acts)
//  bk_slot       in  SLOT_BITS  slot number, sampled at command start
//  nvram_we      in  1   core-side nvram write strobe (dirty tracking)
//  sd_ack        in  1   sector transfer acknowledge (user_io)
//  sd_buff_addr  in  9   byte index within current sector
//  sd_buff_wr    in  1   byte strobe from SD (load direction)
//  sd_lba        out 32  sector address {zeros, slot, sector}
//  sd_rd         out 1   sector read request
//  sd_wr         out 1   sector write request
//  buf_a         out SECTORS_LOG2+9  dpram port B address = {sector, sd_buff_addr}
//  buf_we        out 1   dpram port B write = sd_buff_wr & sd_ack & loading
//  bk_ena        out 1   backup armed
//  bk_busy       out 1   transfer in progress
//  bk_loading    out 1   current/last transfer is a load
//  bk_done       out 1   one-cycle pulse, whole slot transferred
//  bk_err        out 1   one-cycle pulse, transfer aborted on timeout
// BEHAVIOUR
//  - Reset: sd_lba=0, sd_rd=sd_wr=0, bk_busy=0, bk_loading=0, bk_done=0, bk_err=0, FSM IDLE, counters 0.
//    bk_ena and the downloading edge register are NOT reset (power-up 0); they survive core reset,
//    which is asserted throughout download.
//  - bk_ena: cleared on rising edge of downloading; set on any cycle with downloading & img_mounted &
//    img_size!=0. Same cycle: set wins.
//  - Edge detect: load_q <= bk_load&bk_ena, save_q <= bk_save&bk_ena; start on 0->1 of either.
//    Both rising same cycle -> load. Edges while busy are ignored (not queued).
//  - FSM IDLE -> REQ: sd_lba <= {slot,0}, bk_loading <= is_load, sd_rd <= is_load, sd_wr <= ~is_load,
//    bk_busy <= 1, timeout counter cleared. Outputs registered, visible cycle after the edge.
//  - REQ: on sd_ack rise clear sd_rd/sd_wr next cycle -> XFER. Counter reaches TIMEOUT first ->
//    clear sd_rd/sd_wr, bk_busy=0, bk_err pulse, -> IDLE.
//  - XFER: on sd_ack fall: sector field all-ones -> bk_busy=0, bk_done pulse, -> IDLE; else sector+1
//    (slot bits unchanged, no carry into slot), reassert request, counter cleared -> REQ.
//  - buf_a combinational from sd_lba sector field and sd_buff_addr; buf_we only while bk_loading.
//    Save direction: dpram q_b feeds sd_buff_din outside this block.
//  - reset mid-transfer: FSM IDLE immediately, request dropped; no done/err pulse.
// CONFIGURATION
//  BK_AUTOSAVE_EN defined: nvram_we sets dirty; each nvram_we reloads idle counter to 0; counter hitting
//    AUTOSAVE_DLY with dirty & bk_ena & IDLE starts a save to bk_slot as if bk_save rose. dirty cleared
//    at start of any save; set again by nvram_we during the save. Load clears dirty on bk_done.
//  Not defined: nvram_we ignored, no dirty/idle logic; saves only from bk_save edge.
// TESTING
//  1 download with img_mounted, img_size=32768 -> bk_ena=1 after download; new download edge -> 0.
//  2 bk_slot=2, bk_load rise, bench acks 64 sectors -> sd_lba 0x80..0xBF, sd_rd only, buf_we per byte,
//    bk_done once after sector 0xBF ack falls.
//  3 bk_save rise, slot 1 -> sd_wr only, sd_lba 0x40..0x7F, buf_we never asserted, bk_done once.
//  4 bk_load & bk_save rise same cycle -> load; bk_save toggled mid-transfer -> ignored.
//  5 TIMEOUT=100, no sd_ack -> sd_rd drops and bk_err pulses at cycle 100; reset during sector 10 ->
//    all outputs reset values, bk_ena unchanged.
//  6 BK_AUTOSAVE_EN, AUTOSAVE_DLY=50: nvram_we at t=0 -> save starts at t=50; write at t=30 delays to t=80.

Source files
------------

// File: rtl/nvram_backup_ctl.sv
// ============================================================================
//  Module      : nvram_backup_ctl
//  Description : Battery-backup RAM save/load sequencer between the user_io
//                SD sector interface and port B of the cartridge nvram dpram.
//                Arms after a ROM download with a mounted save image, then
//                streams 2^SECTORS_LOG2 x 512-byte sectors per slot.
//                Optional feature macro: BK_AUTOSAVE_EN (idle-time autosave
//                of a dirty nvram).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nvram_backup_ctl #(
    parameter int          SECTORS_LOG2 = 6,
    parameter int          SLOT_BITS    = 2,
    parameter logic [23:0] TIMEOUT      = 24'hFFFFFF,
    parameter logic [23:0] AUTOSAVE_DLY = 24'h800000
) (
    input  logic                      i_clk_sys,
    input  logic                      i_reset,
    input  logic                      i_downloading,
    input  logic                      i_img_mounted,
    input  logic [31:0]               i_img_size,
    input  logic                      i_bk_load,
    input  logic                      i_bk_save,
    input  logic [SLOT_BITS-1:0]      i_bk_slot,
    input  logic                      i_nvram_we,
    input  logic                      i_sd_ack,
    input  logic [8:0]                i_sd_buff_addr,
    input  logic                      i_sd_buff_wr,
    output logic [31:0]               o_sd_lba,
    output logic                      o_sd_rd,
    output logic                      o_sd_wr,
    output logic [SECTORS_LOG2+8:0]   o_buf_a,
    output logic                      o_buf_we,
    output logic                      o_bk_ena,
    output logic                      o_bk_busy,
    output logic                      o_bk_loading,
    output logic                      o_bk_done,
    output logic                      o_bk_err
);

    localparam int c_PAD = 32 - SECTORS_LOG2 - SLOT_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    // Arming state survives core reset (reset is held during download),
    // so these two only carry a power-up value.
    logic r_bk_ena = 1'b0;
    logic r_dl_q   = 1'b0;

    logic                     r_load_q;
    logic                     r_save_q;
    logic                     r_ack_q;

    state_t                   r_state;
    logic [SLOT_BITS-1:0]     r_slot;
    logic [SECTORS_LOG2-1:0]  r_sector;
    logic                     r_rd;
    logic                     r_wr;
    logic                     r_busy;
    logic                     r_loading;
    logic                     r_done;
    logic                     r_err;
    logic [23:0]              r_cnt;

    state_t                   w_state_nxt;
    logic [SLOT_BITS-1:0]     w_slot_nxt;
    logic [SECTORS_LOG2-1:0]  w_sector_nxt;
    logic                     w_rd_nxt;
    logic                     w_wr_nxt;
    logic                     w_busy_nxt;
    logic                     w_loading_nxt;
    logic                     w_done_nxt;
    logic                     w_err_nxt;
    logic [23:0]              w_cnt_nxt;

    logic                     w_load_rise;
    logic                     w_save_rise;
    logic                     w_auto_start;
    logic                     w_ack_rise;
    logic                     w_ack_fall;

    assign w_load_rise = i_bk_load & r_bk_ena & ~r_load_q;
    assign w_save_rise = i_bk_save & r_bk_ena & ~r_save_q;
    assign w_ack_rise  = i_sd_ack & ~r_ack_q;
    assign w_ack_fall  = ~i_sd_ack & r_ack_q;

    // Arm after a download that mounted a non-empty image; disarm on a new download.
    always_ff @(posedge i_clk_sys) begin
        r_dl_q <= i_downloading;
        if (i_downloading && i_img_mounted && (i_img_size != 32'd0)) begin
            r_bk_ena <= 1'b1;
        end else if (i_downloading && !r_dl_q) begin
            r_bk_ena <= 1'b0;
        end
    end

    // Edge history for OSD requests (gated by arming) and for sd_ack.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_load_q <= 1'b0;
            r_save_q <= 1'b0;
            r_ack_q  <= 1'b0;
        end else begin
            r_load_q <= i_bk_load & r_bk_ena;
            r_save_q <= i_bk_save & r_bk_ena;
            r_ack_q  <= i_sd_ack;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_slot    <= '0;
            r_sector  <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_loading <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_slot    <= w_slot_nxt;
            r_sector  <= w_sector_nxt;
            r_rd      <= w_rd_nxt;
            r_wr      <= w_wr_nxt;
            r_busy    <= w_busy_nxt;
            r_loading <= w_loading_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Next-state: start a slot, wait for ack (with timeout), step sectors.
    always_comb begin
        w_state_nxt   = r_state;
        w_slot_nxt    = r_slot;
        w_sector_nxt  = r_sector;
        w_rd_nxt      = r_rd;
        w_wr_nxt      = r_wr;
        w_busy_nxt    = r_busy;
        w_loading_nxt = r_loading;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            S_IDLE: begin
                // Simultaneous load and save edges resolve to a load.
                if (w_load_rise || w_save_rise || w_auto_start) begin
                    w_state_nxt   = S_REQ;
                    w_slot_nxt    = i_bk_slot;
                    w_sector_nxt  = '0;
                    w_loading_nxt = w_load_rise;
                    w_rd_nxt      = w_load_rise;
                    w_wr_nxt      = ~w_load_rise;
                    w_busy_nxt    = 1'b1;
                    w_cnt_nxt     = '0;
                end
            end
            S_REQ: begin
                if (w_ack_rise) begin
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_state_nxt = S_XFER;
                end else if (r_cnt == TIMEOUT - 24'd1) begin
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 24'd1;
                end
            end
            S_XFER: begin
                if (w_ack_fall) begin
                    if (&r_sector) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        // Sector field wraps inside the slot; slot bits never change.
                        w_sector_nxt = r_sector + SECTORS_LOG2'(1);
                        w_rd_nxt     = r_loading;
                        w_wr_nxt     = ~r_loading;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = S_REQ;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef BK_AUTOSAVE_EN
    logic        r_dirty;
    logic [23:0] r_idle_cnt;
    logic        w_save_start;

    assign w_auto_start = r_dirty & r_bk_ena & (r_idle_cnt == AUTOSAVE_DLY);
    assign w_save_start = (r_state == S_IDLE) & ~w_load_rise & (w_save_rise | w_auto_start);

    // Dirty tracking and idle timer; a core write always wins over clearing.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_dirty    <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            if (i_nvram_we) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != AUTOSAVE_DLY) begin
                r_idle_cnt <= r_idle_cnt + 24'd1;
            end
            if (i_nvram_we) begin
                r_dirty <= 1'b1;
            end else if (w_save_start || (w_done_nxt && r_loading)) begin
                r_dirty <= 1'b0;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused     = i_nvram_we ^ (^AUTOSAVE_DLY);
    assign w_auto_start = 1'b0;
`endif

    assign o_sd_lba     = {{c_PAD{1'b0}}, r_slot, r_sector};
    assign o_sd_rd      = r_rd;
    assign o_sd_wr      = r_wr;
    assign o_buf_a      = {r_sector, i_sd_buff_addr};
    assign o_buf_we     = i_sd_buff_wr & i_sd_ack & r_loading;
    assign o_bk_ena     = r_bk_ena;
    assign o_bk_busy    = r_busy;
    assign o_bk_loading = r_loading;
    assign o_bk_done    = r_done;
    assign o_bk_err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_nvram_backup_ctl.sv
// ============================================================================
//  Module      : tb_nvram_backup_ctl
//  Description : Directed self-checking bench for nvram_backup_ctl with a
//                request scoreboard (expected sector requests queued at
//                command start, popped as the DUT raises sd_rd/sd_wr).
//                Autosave steps compile only with BK_AUTOSAVE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nvram_backup_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        downloading;
    logic        img_mounted;
    logic [31:0] img_size;
    logic        bk_load;
    logic        bk_save;
    logic [1:0]  bk_slot;
    logic        nvram_we;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic        sd_buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic [14:0] buf_a;
    logic        buf_we;
    logic        bk_ena;
    logic        bk_busy;
    logic        bk_loading;
    logic        bk_done;
    logic        bk_err;

    always #5 clk = ~clk;

    nvram_backup_ctl #(
        .SECTORS_LOG2 (6),
        .SLOT_BITS    (2),
        .TIMEOUT      (24'd100),
        .AUTOSAVE_DLY (24'd50)
    ) dut (
        .i_clk_sys      (clk),
        .i_reset        (reset),
        .i_downloading  (downloading),
        .i_img_mounted  (img_mounted),
        .i_img_size     (img_size),
        .i_bk_load      (bk_load),
        .i_bk_save      (bk_save),
        .i_bk_slot      (bk_slot),
        .i_nvram_we     (nvram_we),
        .i_sd_ack       (sd_ack),
        .i_sd_buff_addr (sd_buff_addr),
        .i_sd_buff_wr   (sd_buff_wr),
        .o_sd_lba       (sd_lba),
        .o_sd_rd        (sd_rd),
        .o_sd_wr        (sd_wr),
        .o_buf_a        (buf_a),
        .o_buf_we       (buf_we),
        .o_bk_ena       (bk_ena),
        .o_bk_busy      (bk_busy),
        .o_bk_loading   (bk_loading),
        .o_bk_done      (bk_done),
        .o_bk_err       (bk_err)
    );

    typedef struct {
        logic [31:0] lba;
        logic        rd;
        logic        wr;
    } req_t;

    req_t       sb_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         we_cnt   = 0;
    logic [8:0] addrs [4] = '{9'd0, 9'd1, 9'd255, 9'd511};

    // Pulse/strobe counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bk_done) done_cnt++;
        if (bk_err)  err_cnt++;
        if (buf_we)  we_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push_slot(input int slot, input bit ld);
        for (int s = 0; s < 64; s++) begin
            sb_q.push_back(req_t'{lba: 32'(slot * 64 + s), rd: ld, wr: ~ld});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"},   32'(sd_rd),      32'd0);
        check({tag, "_wr"},   32'(sd_wr),      32'd0);
        check({tag, "_busy"}, 32'(bk_busy),    32'd0);
        check({tag, "_ld"},   32'(bk_loading), 32'd0);
        check({tag, "_done"}, 32'(bk_done),    32'd0);
        check({tag, "_err"},  32'(bk_err),     32'd0);
        check({tag, "_lba"},  sd_lba,          32'd0);
    endtask

    // Service one sector request: pop expectation, ack, stream 4 bytes, release ack.
    task automatic serve_sector(input bit ld, output bit ok);
        req_t e;
        int   w;
        w = 0;
        while (!(sd_rd || sd_wr) && w < 20) begin
            tick;
            w++;
        end
        check("req_seen", 32'(sd_rd | sd_wr), 32'd1);
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        ok = (sd_rd || sd_wr) && (sb_q.size() > 0);
        if (!ok) return;
        e = sb_q.pop_front();
        check("lba", sd_lba, e.lba);
        check("rd",  32'(sd_rd), 32'(e.rd));
        check("wr",  32'(sd_wr), 32'(e.wr));
        sd_ack = 1'b1;
        tick;
        check("req_drop", 32'(sd_rd | sd_wr), 32'd0);
        for (int b = 0; b < 4; b++) begin
            sd_buff_addr = addrs[b];
            sd_buff_wr   = 1'b1;
            #1;
            check("buf_we", 32'(buf_we), 32'(ld));
            check("buf_a",  32'(buf_a),  {17'd0, e.lba[5:0], addrs[b]});
            tick;
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        tick;
    endtask

    task automatic serve_slot(input bit ld, input int n, input bit toggle_save);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (toggle_save && i == 5) bk_save = 1'b1;
            if (toggle_save && i == 7) bk_save = 1'b0;
            serve_sector(ld, ok);
            if (!ok) break;
        end
    endtask

    // Right after the final ack release: one done pulse, not busy.
    task automatic check_done(input string tag, input int d0);
        check({tag, "_done"}, 32'(bk_done), 32'd1);
        check({tag, "_busy"}, 32'(bk_busy), 32'd0);
        tick;
        check({tag, "_done_clr"}, 32'(bk_done), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(d0 + 1));
    endtask

    initial begin
        int d0;
        int e0;
        int we0;
        int w;
        reset        = 1'b1;
        downloading  = 1'b0;
        img_mounted  = 1'b0;
        img_size     = 32'd0;
        bk_load      = 1'b0;
        bk_save      = 1'b0;
        bk_slot      = 2'd0;
        nvram_we     = 1'b0;
        sd_ack       = 1'b0;
        sd_buff_addr = 9'd0;
        sd_buff_wr   = 1'b0;
        repeat (3) tick;

        check_reset_outputs("rst");
        check("rst_ena", 32'(bk_ena), 32'd0);

        // Download with save image mounted, core reset held throughout.
        downloading = 1'b1;
        tick;
        img_mounted = 1'b1;
        img_size    = 32'd32768;
        tick;
        img_mounted = 1'b0;
        tick;
        downloading = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        check("ena_armed", 32'(bk_ena), 32'd1);

        // A new download edge disarms.
        downloading = 1'b1;
        tick;
        check("ena_dl_edge", 32'(bk_ena), 32'd0);
        downloading = 1'b0;
        tick;

        // Download edge together with a mount: set wins.
        downloading = 1'b1;
        img_mounted = 1'b1;
        tick;
        check("ena_set_wins", 32'(bk_ena), 32'd1);
        img_mounted = 1'b0;
        downloading = 1'b0;
        tick;
        check("ena_hold", 32'(bk_ena), 32'd1);

        // Load slot 2: LBAs 0x80..0xBF, read requests, byte writes into dpram.
        bk_slot = 2'd2;
        push_slot(2, 1'b1);
        d0  = done_cnt;
        we0 = we_cnt;
        bk_load = 1'b1;
        tick;
        bk_load = 1'b0;
        check("ld_busy", 32'(bk_busy),    32'd1);
        check("ld_flag", 32'(bk_loading), 32'd1);
        serve_slot(1'b1, 64, 1'b0);
        check_done("ld", d0);
        check("ld_we_cnt", 32'(we_cnt), 32'(we0 + 256));

        // Save slot 1: LBAs 0x40..0x7F, write requests, never a dpram write.
        bk_slot = 2'd1;
        push_slot(1, 1'b0);
        d0  = done_cnt;
        we0 = we_cnt;
        bk_save = 1'b1;
        tick;
        bk_save = 1'b0;
        check("sv_flag", 32'(bk_loading), 32'd0);
        serve_slot(1'b0, 64, 1'b0);
        check_done("sv", d0);
        check("sv_we_cnt", 32'(we_cnt), 32'(we0));

        // Load and save rising together -> load; mid-transfer save edge ignored.
        bk_slot = 2'd3;
        push_slot(3, 1'b1);
        d0 = done_cnt;
        bk_load = 1'b1;
        bk_save = 1'b1;
        tick;
        bk_load = 1'b0;
        bk_save = 1'b0;
        check("both_ld", 32'(bk_loading), 32'd1);
        serve_slot(1'b1, 64, 1'b1);
        check_done("both", d0);
        repeat (5) tick;
        check("both_no_requeue_busy", 32'(bk_busy), 32'd0);
        check("both_no_requeue_wr",   32'(sd_wr),   32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        // No ack: request held for 100 cycles, then abort with one err pulse.
        bk_slot = 2'd0;
        e0 = err_cnt;
        bk_load = 1'b1;
        tick;
        bk_load = 1'b0;
        check("to_rd_start", 32'(sd_rd), 32'd1);
        repeat (99) tick;
        check("to_rd_hold",  32'(sd_rd),  32'd1);
        check("to_err_hold", 32'(bk_err), 32'd0);
        tick;
        check("to_rd_drop", 32'(sd_rd),   32'd0);
        check("to_err",     32'(bk_err),  32'd1);
        check("to_busy",    32'(bk_busy), 32'd0);
        tick;
        check("to_err_clr", 32'(bk_err),  32'd0);
        check("to_err_cnt", 32'(err_cnt), 32'(e0 + 1));

        // Reset while sector 10 is being transferred.
        bk_slot = 2'd2;
        push_slot(2, 1'b1);
        d0 = done_cnt;
        e0 = err_cnt;
        bk_load = 1'b1;
        tick;
        bk_load = 1'b0;
        serve_slot(1'b1, 10, 1'b0);
        check("mid_lba", sd_lba, 32'h8A);
        check("mid_rd",  32'(sd_rd), 32'd1);
        sd_ack = 1'b1;
        tick;
        reset = 1'b1;
        tick;
        check_reset_outputs("midrst");
        check("midrst_ena", 32'(bk_ena), 32'd1);
        sd_ack = 1'b0;
        reset  = 1'b0;
        sb_q.delete();
        repeat (3) tick;
        check("midrst_idle",     32'(bk_busy),  32'd0);
        check("midrst_no_done",  32'(done_cnt), 32'(d0));
        check("midrst_no_err",   32'(err_cnt),  32'(e0));

`ifdef BK_AUTOSAVE_EN
        // Single write: save decided 50 idle cycles later, request visible next cycle.
        bk_slot = 2'd2;
        push_slot(2, 1'b0);
        d0 = done_cnt;
        nvram_we = 1'b1;
        tick;
        nvram_we = 1'b0;
        w = 0;
        while (!sd_wr && w < 200) begin
            tick;
            w++;
        end
        check("auto_lat", 32'(w), 32'd51);
        serve_slot(1'b0, 64, 1'b0);
        check_done("auto1", d0);

        // Second write at t=30 restarts the idle interval.
        push_slot(2, 1'b0);
        d0 = done_cnt;
        nvram_we = 1'b1;
        tick;
        nvram_we = 1'b0;
        repeat (29) tick;
        nvram_we = 1'b1;
        tick;
        nvram_we = 1'b0;
        w = 30;
        while (!sd_wr && w < 300) begin
            tick;
            w++;
        end
        check("auto_lat2", 32'(w), 32'd81);
        serve_slot(1'b0, 64, 1'b0);
        check_done("auto2", d0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
